regwb_ctrl: RTL and testbench

REGWB_CTRL -- requirements
Module: regwb_ctrl

---
 rtl/regwb_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_regwb_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regwb_ctrl.sv
// Write-back controller: load scoreboard, pending-load counter, one-entry load buffer
// and register-file write-port arbitration. Optional bypass enabled by REGWB_FORWARD_EN.
// T (and every other ordinary code) is written raw; the register file derives T.
module regwb_ctrl #(
    parameter logic [3:0] REG0 = 4'd0,
    parameter logic [3:0] PC   = 4'd15
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        IssueValid,
    input  logic        IssueIsLoad,
    input  logic [3:0]  IssueRd,
    input  logic [3:0]  IssueRs,
    input  logic [3:0]  IssueRt,
    output logic        Stall,
    input  logic        AluValid,
    input  logic [3:0]  AluRd,
    input  logic [15:0] AluData,
    input  logic        MemValid,
    output logic        MemReady,
    input  logic [3:0]  MemRd,
    input  logic [15:0] MemData,
    output logic        RegWre,
    output logic [3:0]  WriteReg,
    output logic [15:0] WriteData,
    output logic        FwdHit1,
    output logic        FwdHit2,
    output logic [15:0] FwdData1,
    output logic [15:0] FwdData2
);

    localparam int unsigned REG_W  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 16;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(7);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } buf_state_e;

    buf_state_e          r_state;
    buf_state_e          w_state_nxt;

    logic [NREGS-1:0]    r_busy;
    logic [NREGS-1:0]    w_busy_nxt;
    logic [CNT_W-1:0]    r_pend_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    logic [REG_W-1:0]    r_buf_rd;
    logic [DATA_W-1:0]   r_buf_data;

    logic                r_reg_wre;
    logic [REG_W-1:0]    r_write_reg;
    logic [DATA_W-1:0]   r_write_data;

    logic                w_capture;
    logic                w_sel_alu;
    logic                w_sel_buf;
    logic                w_sel_mem;
    logic                w_wr_valid;
    logic                w_load_wr;
    logic [REG_W-1:0]    w_wr_rd;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_wr_commit;

    logic                w_fwd_hit1;
    logic                w_fwd_hit2;
    logic                w_stall;
    logic                w_load_issue;

    function automatic logic f_writable(input logic [REG_W-1:0] rd);
        return (rd != REG0) && (rd != PC);
    endfunction

    // Load buffer state register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Buffer next state and write-port source select (ALU > held load > new load)
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_sel_alu   = AluValid;
        w_sel_buf   = 1'b0;
        w_sel_mem   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (MemValid) begin
                    if (AluValid) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_HELD;
                    end else begin
                        w_sel_mem = 1'b1;
                    end
                end
            end
            ST_HELD: begin
                if (!AluValid) begin
                    w_sel_buf   = 1'b1;
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    assign MemReady  = (r_state == ST_EMPTY);
    assign w_load_wr = w_sel_buf | w_sel_mem;
    assign w_wr_valid = w_sel_alu | w_load_wr;

    always_comb begin
        w_wr_rd   = MemRd;
        w_wr_data = MemData;
        if (w_sel_alu) begin
            w_wr_rd   = AluRd;
            w_wr_data = AluData;
        end else if (w_sel_buf) begin
            w_wr_rd   = r_buf_rd;
            w_wr_data = r_buf_data;
        end
    end

    assign w_wr_commit = w_wr_valid & f_writable(w_wr_rd);

    // Load captured while the ALU owns the port
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_buf_rd   <= '0;
            r_buf_data <= '0;
        end else if (w_capture) begin
            r_buf_rd   <= MemRd;
            r_buf_data <= MemData;
        end
    end

    // Registered write port; REG0/PC destinations are dropped
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_reg_wre    <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            r_reg_wre <= w_wr_commit;
            if (w_wr_commit) begin
                r_write_reg  <= w_wr_rd;
                r_write_data <= w_wr_data;
            end
        end
    end

    assign RegWre    = r_reg_wre;
    assign WriteReg  = r_write_reg;
    assign WriteData = r_write_data;

`ifdef REGWB_FORWARD_EN
    assign w_fwd_hit1 = r_reg_wre && (r_write_reg == IssueRs) && f_writable(IssueRs);
    assign w_fwd_hit2 = r_reg_wre && (r_write_reg == IssueRt) && f_writable(IssueRt);
    assign FwdData1   = w_fwd_hit1 ? r_write_data : '0;
    assign FwdData2   = w_fwd_hit2 ? r_write_data : '0;
`else
    assign w_fwd_hit1 = 1'b0;
    assign w_fwd_hit2 = 1'b0;
    assign FwdData1   = '0;
    assign FwdData2   = '0;
`endif

    assign FwdHit1 = w_fwd_hit1;
    assign FwdHit2 = w_fwd_hit2;

    // Source hazards are waived when the value is on the bypass this cycle
    assign w_stall = IssueValid & ((r_busy[IssueRs] & ~w_fwd_hit1) |
                                   (r_busy[IssueRt] & ~w_fwd_hit2) |
                                   r_busy[IssueRd] |
                                   (IssueIsLoad & (r_pend_cnt == CNT_MAX)));
    assign Stall = w_stall;

    assign w_load_issue = IssueValid & IssueIsLoad & ~w_stall;

    // Clear on load write first so a coinciding set wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_load_wr) begin
            w_busy_nxt[w_wr_rd] = 1'b0;
        end
        if (w_load_issue && f_writable(IssueRd)) begin
            w_busy_nxt[IssueRd] = 1'b1;
        end
    end

    // Saturating pending-load count
    always_comb begin
        w_cnt_nxt = r_pend_cnt;
        if (w_load_issue && !w_load_wr) begin
            if (r_pend_cnt != CNT_MAX) begin
                w_cnt_nxt = r_pend_cnt + CNT_W'(1);
            end
        end else if (!w_load_issue && w_load_wr) begin
            if (r_pend_cnt != '0) begin
                w_cnt_nxt = r_pend_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= w_cnt_nxt;
        end
    end

    a_no_reserved_write: assert property (@(posedge Clk) disable iff (!Rst)
        r_reg_wre |-> f_writable(r_write_reg));
    a_no_reserved_busy: assert property (@(posedge Clk) disable iff (!Rst)
        !r_busy[REG0] && !r_busy[PC]);

endmodule

// File: tb/tb_regwb_ctrl.sv
// Scoreboard bench for regwb_ctrl: expected writes queued at stimulus time, popped on RegWre.
module tb_regwb_ctrl;

    localparam logic [3:0] REG0 = 4'd0;
    localparam logic [3:0] T    = 4'd14;
    localparam logic [3:0] PC   = 4'd15;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        IssueValid, IssueIsLoad;
    logic [3:0]  IssueRd, IssueRs, IssueRt;
    logic        Stall;
    logic        AluValid;
    logic [3:0]  AluRd;
    logic [15:0] AluData;
    logic        MemValid, MemReady;
    logic [3:0]  MemRd;
    logic [15:0] MemData;
    logic        RegWre;
    logic [3:0]  WriteReg;
    logic [15:0] WriteData;
    logic        FwdHit1, FwdHit2;
    logic [15:0] FwdData1, FwdData2;

    int n_cmp = 0;
    int n_err = 0;
    logic [19:0] exp_q[$];
    logic [19:0] sb_e;

    regwb_ctrl dut (
        .Clk(Clk), .Rst(Rst),
        .IssueValid(IssueValid), .IssueIsLoad(IssueIsLoad),
        .IssueRd(IssueRd), .IssueRs(IssueRs), .IssueRt(IssueRt),
        .Stall(Stall),
        .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData),
        .MemValid(MemValid), .MemReady(MemReady), .MemRd(MemRd), .MemData(MemData),
        .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
        .FwdHit1(FwdHit1), .FwdHit2(FwdHit2), .FwdData1(FwdData1), .FwdData2(FwdData2)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic sb_push(input logic [3:0] rd, input logic [15:0] data);
        exp_q.push_back({rd, data});
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        IssueValid = 1'b0; IssueIsLoad = 1'b0;
        IssueRd = '0; IssueRs = '0; IssueRt = '0;
        AluValid = 1'b0; AluRd = '0; AluData = '0;
        MemValid = 1'b0; MemRd = '0; MemData = '0;
    endtask

    // Write-port monitor: every presented write must match the head of the queue
    always @(negedge Clk) begin
        if (RegWre === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", 32'(RegWre), 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                check_eq("wr_reg", 32'(WriteReg), 32'(sb_e[19:16]));
                check_eq("wr_data", 32'(WriteData), 32'(sb_e[15:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        Rst = 1'b0;
        // Reset holds everything idle even with traffic present
        IssueValid = 1'b1; IssueIsLoad = 1'b1; IssueRd = 4'd3; IssueRs = 4'd3; IssueRt = 4'd3;
        AluValid = 1'b1; AluRd = 4'd6; AluData = 16'h1234;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_eq("rst_regwre", 32'(RegWre), 32'd0);
        check_eq("rst_memready", 32'(MemReady), 32'd1);
        check_eq("rst_stall", 32'(Stall), 32'd0);
        check_eq("rst_writereg", 32'(WriteReg), 32'd0);
        check_eq("rst_writedata", 32'(WriteData), 32'd0);
        check_eq("rst_fwdhit1", 32'(FwdHit1), 32'd0);
        step();
        IssueValid = 1'b0; IssueIsLoad = 1'b0;
        Rst = 1'b1;
        sb_push(4'd6, 16'h1234);
        step();
        AluValid = 1'b0;
        @(negedge Clk);
        check_eq("first_wre", 32'(RegWre), 32'd1);
        step();

        // Load r3 blocks a reader of r3 until its write is on the port
        IssueValid = 1'b1; IssueIsLoad = 1'b1; IssueRd = 4'd3; IssueRs = 4'd1; IssueRt = 4'd2;
        @(negedge Clk);
        check_eq("ld3_issue", 32'(Stall), 32'd0);
        step();
        IssueIsLoad = 1'b0; IssueRd = 4'd7; IssueRs = 4'd3; IssueRt = 4'd1;
        repeat (2) begin
            @(negedge Clk);
            check_eq("rs_busy", 32'(Stall), 32'd1);
            step();
        end
        MemValid = 1'b1; MemRd = 4'd3; MemData = 16'h00FF;
        sb_push(4'd3, 16'h00FF);
        @(negedge Clk);
        check_eq("rs_busy_ret", 32'(Stall), 32'd1);
        check_eq("ret_ready", 32'(MemReady), 32'd1);
        step();
        MemValid = 1'b0;
        @(negedge Clk);
        check_eq("rs_free", 32'(Stall), 32'd0);
        check_eq("rs_free_wreg", 32'(WriteReg), 32'd3);
        step();
        IssueValid = 1'b0;

        // Rt and Rd hazards
        IssueValid = 1'b1; IssueIsLoad = 1'b1; IssueRd = 4'd9; IssueRs = 4'd1; IssueRt = 4'd2;
        step();
        IssueIsLoad = 1'b0; IssueRd = 4'd7; IssueRs = 4'd1; IssueRt = 4'd9;
        @(negedge Clk);
        check_eq("rt_busy", 32'(Stall), 32'd1);
        #1 IssueRt = 4'd1; IssueRd = 4'd9;
        #1 check_eq("rd_busy", 32'(Stall), 32'd1);
        IssueRd = 4'd8;
        #1 check_eq("no_busy", 32'(Stall), 32'd0);
        step();
        IssueValid = 1'b0;
        MemValid = 1'b1; MemRd = 4'd9; MemData = 16'h0909;
        sb_push(4'd9, 16'h0909);
        step();
        MemValid = 1'b0;
        step();

        // ALU and load collide: ALU first, load one cycle later
        AluValid = 1'b1; AluRd = 4'd2; AluData = 16'hAAAA;
        MemValid = 1'b1; MemRd = 4'd4; MemData = 16'h5555;
        sb_push(4'd2, 16'hAAAA);
        sb_push(4'd4, 16'h5555);
        @(negedge Clk);
        check_eq("coll_ready_pre", 32'(MemReady), 32'd1);
        step();
        AluValid = 1'b0; MemValid = 1'b0;
        @(negedge Clk);
        check_eq("coll_held", 32'(MemReady), 32'd0);
        step();
        @(negedge Clk);
        check_eq("coll_drained", 32'(MemReady), 32'd1);
        step();

        // Held load waits while the ALU keeps the port
        AluValid = 1'b1; AluRd = 4'd10; AluData = 16'h1111;
        MemValid = 1'b1; MemRd = 4'd11; MemData = 16'h2222;
        sb_push(4'd10, 16'h1111);
        step();
        MemValid = 1'b0; AluRd = 4'd12; AluData = 16'h3333;
        sb_push(4'd12, 16'h3333);
        @(negedge Clk);
        check_eq("hold1_ready", 32'(MemReady), 32'd0);
        step();
        AluValid = 1'b0;
        sb_push(4'd11, 16'h2222);
        @(negedge Clk);
        check_eq("hold2_ready", 32'(MemReady), 32'd0);
        step();
        @(negedge Clk);
        check_eq("hold_drained", 32'(MemReady), 32'd1);
        step();

        // Reserved destinations are dropped; T is written raw
        AluValid = 1'b1; AluRd = REG0; AluData = 16'hDEAD;
        step();
        AluRd = PC; AluData = 16'hBEEF;
        @(negedge Clk);
        check_eq("sup_reg0", 32'(RegWre), 32'd0);
        step();
        AluRd = T; AluData = 16'h0000;
        sb_push(T, 16'h0000);
        @(negedge Clk);
        check_eq("sup_pc", 32'(RegWre), 32'd0);
        step();
        AluValid = 1'b0;
        @(negedge Clk);
        check_eq("t_write", 32'(RegWre), 32'd1);
        step();

        // Pending-load limit of seven
        IssueValid = 1'b1; IssueIsLoad = 1'b1; IssueRs = REG0; IssueRt = REG0;
        for (int i = 1; i <= 7; i++) begin
            IssueRd = 4'(i);
            @(negedge Clk);
            check_eq("cnt_fill", 32'(Stall), 32'd0);
            step();
        end
        IssueRd = 4'd8;
        @(negedge Clk);
        check_eq("cnt_full_load", 32'(Stall), 32'd1);
        #1 IssueIsLoad = 1'b0;
        #1 check_eq("cnt_full_nonload", 32'(Stall), 32'd0);
        IssueIsLoad = 1'b1;
        step();
        MemValid = 1'b1; MemRd = 4'd1; MemData = 16'hA001;
        sb_push(4'd1, 16'hA001);
        @(negedge Clk);
        check_eq("cnt_full_ret", 32'(Stall), 32'd1);
        step();
        MemValid = 1'b0;
        @(negedge Clk);
        check_eq("cnt_after_ret", 32'(Stall), 32'd0);
        step();
        IssueValid = 1'b0; IssueIsLoad = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            MemValid = 1'b1; MemRd = 4'(i); MemData = 16'hA000 + 16'(i);
            sb_push(4'(i), 16'hA000 + 16'(i));
            step();
        end
        MemValid = 1'b0;
        step();
        IssueValid = 1'b1; IssueIsLoad = 1'b1; IssueRd = 4'd9; IssueRs = 4'd2; IssueRt = 4'd8;
        @(negedge Clk);
        check_eq("cnt_empty", 32'(Stall), 32'd0);
        #1 IssueValid = 1'b0; IssueIsLoad = 1'b0;
        step();

        // Load r5 returns while a reader of r5 issues
        IssueValid = 1'b1; IssueIsLoad = 1'b1; IssueRd = 4'd5; IssueRs = 4'd1; IssueRt = 4'd1;
        step();
        IssueIsLoad = 1'b0; IssueRd = 4'd6; IssueRs = 4'd5; IssueRt = 4'd5;
        MemValid = 1'b1; MemRd = 4'd5; MemData = 16'hBEEF;
        sb_push(4'd5, 16'hBEEF);
        @(negedge Clk);
        check_eq("fwd_pending", 32'(Stall), 32'd1);
        step();
        MemValid = 1'b0;
        @(negedge Clk);
        check_eq("fwd_stall", 32'(Stall), 32'd0);
`ifdef REGWB_FORWARD_EN
        check_eq("fwd_hit1", 32'(FwdHit1), 32'd1);
        check_eq("fwd_data1", 32'(FwdData1), 32'hBEEF);
        check_eq("fwd_hit2", 32'(FwdHit2), 32'd1);
        check_eq("fwd_data2", 32'(FwdData2), 32'hBEEF);
`else
        check_eq("fwd_hit1_off", 32'(FwdHit1), 32'd0);
        check_eq("fwd_data1_off", 32'(FwdData1), 32'd0);
        check_eq("fwd_hit2_off", 32'(FwdHit2), 32'd0);
        check_eq("fwd_data2_off", 32'(FwdData2), 32'd0);
`endif
        step();
        IssueValid = 1'b0;
        step();

        // Reset mid-operation drops the held load and the scoreboard
        IssueValid = 1'b1; IssueIsLoad = 1'b1; IssueRd = 4'd3; IssueRs = 4'd1; IssueRt = 4'd2;
        step();
        IssueValid = 1'b0; IssueIsLoad = 1'b0;
        AluValid = 1'b1; AluRd = 4'd2; AluData = 16'h1357;
        MemValid = 1'b1; MemRd = 4'd4; MemData = 16'h2468;
        step();
        Rst = 1'b0;
        AluValid = 1'b0; MemValid = 1'b0;
        IssueValid = 1'b1; IssueIsLoad = 1'b1; IssueRd = 4'd3; IssueRs = 4'd3; IssueRt = 4'd4;
        #1;
        check_eq("mrst_wre", 32'(RegWre), 32'd0);
        check_eq("mrst_ready", 32'(MemReady), 32'd1);
        check_eq("mrst_stall", 32'(Stall), 32'd0);
        IssueValid = 1'b0; IssueIsLoad = 1'b0;
        step();
        step();
        Rst = 1'b1;
        repeat (3) step();
        IssueValid = 1'b1; IssueIsLoad = 1'b1; IssueRd = 4'd3; IssueRs = 4'd3; IssueRt = 4'd4;
        @(negedge Clk);
        check_eq("post_rst_busy", 32'(Stall), 32'd0);
        check_eq("post_rst_ready", 32'(MemReady), 32'd1);
        #1 IssueValid = 1'b0; IssueIsLoad = 1'b0;
        repeat (2) step();

        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
